// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM channel arbiter: access-size codes,
// controller state encodings and byte-lane index helpers.
package bram_pkg;

    typedef enum logic [1:0] {
        MODE_WORD = 2'b00,
        MODE_HALF = 2'b01,
        MODE_BYTE = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CHK  = 3'd1,
        ST_RD   = 3'd2,
        ST_RDW  = 3'd3,
        ST_MWR  = 3'd4,
        ST_WR   = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam int LANE_W = 8;

    // Number of whole byte lanes in a memory word.
    function automatic int byte_lanes(input int data_w);
        return data_w / LANE_W;
    endfunction

    // Bit position of the least significant bit of a byte lane.
    function automatic int lane_lsb(input logic [2:0] lane);
        return int'(lane) * LANE_W;
    endfunction

endpackage

// File: rtl/bram_sp.sv
// Single-port synchronous RAM, one-cycle read latency. Read data is only
// updated by read cycles so it stays stable across the following states.
module bram_sp #(
    parameter int DATA_W = 40,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Synchronous write or registered read of one word per enabled cycle.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/bram_chan_arbiter.sv
// N-channel round-robin access controller in front of one single-port BRAM.
// Handles WORD/HALF/BYTE accesses; partial stores are read-modify-write.
module bram_chan_arbiter
    import bram_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int DATA_W = 40,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          req,
    input  logic [NCH-1:0]          rw,
    input  logic [2*NCH-1:0]        mode,
    input  logic [ADDR_W*NCH-1:0]   addr,
    input  logic [DATA_W*NCH-1:0]   wdata,
    output logic [NCH-1:0]          ack,
    output logic [NCH-1:0]          err,
    output logic [DATA_W*NCH-1:0]   rdata
);

    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LANES   = byte_lanes(DATA_W);
    localparam int HALF_W  = DATA_W / 2;
    localparam int RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WADDR_W = ADDR_W - 3;

    logic [1:0]        mode_a  [NCH];
    logic [ADDR_W-1:0] addr_a  [NCH];
    logic [DATA_W-1:0] wdata_a [NCH];
    logic [DATA_W-1:0] rdata_a [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        assign mode_a[c]                  = mode[2*c +: 2];
        assign addr_a[c]                  = addr[ADDR_W*c +: ADDR_W];
        assign wdata_a[c]                 = wdata[DATA_W*c +: DATA_W];
        assign rdata[DATA_W*c +: DATA_W]  = rdata_a[c];
    end

    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   cur_ch;
    logic              bad_q;
    logic              cur_rw;
    mode_t             cur_mode;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [DATA_W-1:0] word_q;

    logic              gnt_found;
    logic [CH_W-1:0]   gnt_ch;
    logic              bad;
    logic [WADDR_W-1:0] waddr;
    logic [2:0]        lane;

    logic              ram_en;
    logic              ram_we;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    // Channel index a given distance past the round-robin pointer.
    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] base,
                                                 input int unsigned     step);
        return CH_W'((32'(base) + step) % NCH);
    endfunction

    // Replace the addressed lane of a stored word; other bits are kept exactly.
    function automatic logic [DATA_W-1:0] merge_lane(input logic [DATA_W-1:0] old_word,
                                                     input logic [DATA_W-1:0] new_data,
                                                     input mode_t             m,
                                                     input logic [2:0]        lo);
        logic [DATA_W-1:0] res;
        res = old_word;
        case (m)
            MODE_HALF: begin
                if (lo[0]) res[DATA_W-1 -: HALF_W] = new_data[HALF_W-1:0];
                else       res[HALF_W-1:0]         = new_data[HALF_W-1:0];
            end
            MODE_BYTE: res[lane_lsb(lo) +: LANE_W] = new_data[LANE_W-1:0];
            default:   res = new_data;
        endcase
        return res;
    endfunction

    // Pull the addressed lane out of a word, zero-extended to full width.
    function automatic logic [DATA_W-1:0] extract_lane(input logic [DATA_W-1:0] word,
                                                       input mode_t             m,
                                                       input logic [2:0]        lo);
        logic [DATA_W-1:0] res;
        case (m)
            MODE_HALF: res = lo[0] ? DATA_W'(word[DATA_W-1 -: HALF_W])
                                   : DATA_W'(word[HALF_W-1:0]);
            MODE_BYTE: res = DATA_W'(word[lane_lsb(lo) +: LANE_W]);
            default:   res = word;
        endcase
        return res;
    endfunction

    assign waddr = cur_addr[ADDR_W-1:3];
    assign lane  = cur_addr[2:0];
    assign bad   = (cur_mode == MODE_RSVD)
                || (32'(waddr) >= 32'(DEPTH))
                || ((cur_mode == MODE_BYTE) && (32'(lane) >= 32'(LANES)));

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            if (!gnt_found && req[next_ch(rr_ptr, i)]) begin
                gnt_found = 1'b1;
                gnt_ch    = next_ch(rr_ptr, i);
            end
        end
    end

    // BRAM port drive: read in RD, merged write in MWR, full-word write in WR.
    // MWR doubles as the write beat of a partial store because the merge is only
    // a lane mux on the already captured word.
    always_comb begin
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        ram_din = cur_wdata;
        case (state)
            ST_RD: ram_en = 1'b1;
            ST_MWR: begin
                ram_en  = 1'b1;
                ram_we  = 1'b1;
                ram_din = merge_lane(word_q, cur_wdata, cur_mode, lane);
            end
            ST_WR: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
            end
            default: ;
        endcase
    end

    // Controller FSM with registered ack/err/rdata outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            rr_ptr <= CH_W'(NCH - 1);
            cur_ch <= '0;
            bad_q  <= 1'b0;
            ack    <= '0;
            err    <= '0;
            for (int c = 0; c < NCH; c++) rdata_a[c] <= '0;
        end else begin
            ack <= '0;
            err <= '0;
            case (state)
                ST_IDLE: begin
                    if (gnt_found) begin
                        state  <= ST_CHK;
                        rr_ptr <= gnt_ch;
                        cur_ch <= gnt_ch;
                    end
                end
                ST_CHK: begin
                    bad_q <= bad;
                    if (bad)                                 state <= ST_DONE;
                    else if (!cur_rw && cur_mode == MODE_WORD) state <= ST_WR;
                    else                                     state <= ST_RD;
                end
                ST_RD:   state <= ST_RDW;
                ST_RDW:  state <= cur_rw ? ST_DONE : ST_MWR;
                ST_MWR:  state <= ST_DONE;
                ST_WR:   state <= ST_DONE;
                ST_DONE: begin
                    ack[cur_ch] <= 1'b1;
                    err[cur_ch] <= bad_q;
                    if (cur_rw && !bad_q) begin
                        rdata_a[cur_ch] <= extract_lane(word_q, cur_mode, lane);
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Request latch at grant and capture of BRAM read data in RDW.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && gnt_found) begin
            cur_rw    <= rw[gnt_ch];
            cur_mode  <= mode_t'(mode_a[gnt_ch]);
            cur_addr  <= addr_a[gnt_ch];
            cur_wdata <= wdata_a[gnt_ch];
        end
        if (state == ST_RDW) begin
            word_q <= ram_dout;
        end
    end

    bram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (cur_addr[3 +: RAM_AW]),
        .din  (ram_din),
        .dout (ram_dout)
    );

endmodule
